// File: rtl/key_debounce.sv
// key_debounce
// Debounce and edge-detect stage for one active-low push-button.
// The raw pin is synchronized through two flops, then an FSM requires the
// synchronized level to hold for DEB_CNT cycles before the clean level moves.
// A single saturating counter times both the debounce window and the long press.
//
// Optional feature macro: KEY_DEBOUNCE_LONGPRESS_EN
//   defined   : key_long pulses once LONG_CNT cycles after key_press
//   undefined : key_long tied to 0, counter sized for DEB_CNT only
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   key         raw button pin, low = pressed
//   key_clean   debounced level, low = pressed
//   key_press   one-cycle pulse when key_clean falls
//   key_release one-cycle pulse when key_clean rises
//   key_long    one-cycle pulse after a long press
//
// state   | meaning
// IDLE    | released, clean level high
// P_FILT  | key_s low, waiting for a stable press
// PRESSED | pressed, clean level low, long-press timing runs
// R_FILT  | key_s high, waiting for a stable release

module key_debounce #(
    parameter int DEB_CNT  = 1_000_000,
    parameter int LONG_CNT = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic key_clean,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    localparam int CNT_W = $clog2(LONG_CNT + 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CNT);
`else
    localparam int CNT_W = $clog2(DEB_CNT);
`endif
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        P_FILT  = 2'd1,
        PRESSED = 2'd2,
        R_FILT  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             sync2;
    logic             key_s;

    assign key_s = sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            key_clean   <= 1'b1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
            key_long    <= 1'b0;
`endif
        end else begin
            sync1       <= key;
            sync2       <= sync1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
            key_long    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state <= P_FILT;
                        cnt   <= '0;
                    end
                end
                P_FILT: begin
                    if (key_s) begin
                        state <= IDLE;
                    end else if (cnt == DEB_LAST) begin
                        state     <= PRESSED;
                        key_clean <= 1'b0;
                        key_press <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (key_s) begin
                        state <= R_FILT;
                        cnt   <= '0;
                    end
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
                    else begin
                        // Saturating at LONG_CNT makes the compare below true only once.
                        if (cnt < LONG_MAX)
                            cnt <= cnt + 1'b1;
                        if (cnt == LONG_LAST)
                            key_long <= 1'b1;
                    end
`endif
                end
                R_FILT: begin
                    if (!key_s) begin
                        // Bounce back to pressed: long-press timing restarts from zero.
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state       <= IDLE;
                        key_clean   <= 1'b1;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifndef KEY_DEBOUNCE_LONGPRESS_EN
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;
    localparam int DEB  = 4;
    localparam int LONG = 20;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key = 1'b1;
    logic key_clean, key_press, key_release, key_long;
    logic [3:0] obs;
    assign obs = {key_clean, key_press, key_release, key_long};

    key_debounce #(.DEB_CNT(DEB), .LONG_CNT(LONG)) dut (
        .clk(clk), .rst_n(rst_n), .key(key),
        .key_clean(key_clean), .key_press(key_press),
        .key_release(key_release), .key_long(key_long)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the button level seen by the debouncer lags the pin by two
    // clock edges; the clean level flips once DEB+1 consecutive samples disagree
    // with it; a long press is LONG edges of unbroken low samples after the press
    // (or after a release bounce that returned to pressed).
    logic       pipe0, pipe1;
    logic       m_clean;
    int         run_len;
    bit         armed;
    int         age;
    logic [3:0] expv;

    int edge_no, n_press, n_release, n_long;
    int press_edge, release_edge, long_edge;

    task automatic model_reset();
        pipe0 = 1'b1; pipe1 = 1'b1;
        m_clean = 1'b1; run_len = 0; armed = 1'b0; age = 0;
        expv = 4'b1000;
    endtask

    task automatic clear_obs();
        n_press = 0; n_release = 0; n_long = 0;
        press_edge = -1; release_edge = -1; long_edge = -1;
    endtask

    task automatic step(input logic k);
        logic ks;
        logic p, r, l;
        bit committed;
        key = k;
        @(posedge clk);
        edge_no++;
        ks = pipe1;
        pipe1 = pipe0;
        pipe0 = k;
        p = 1'b0; r = 1'b0; l = 1'b0; committed = 1'b0;
        if (ks != m_clean) begin
            run_len++;
            if (run_len == DEB + 1) begin
                m_clean = ks;
                run_len = 0;
                committed = 1'b1;
                if (ks == 1'b0) begin
                    p = 1'b1; armed = 1'b1; age = 0;
                end else begin
                    r = 1'b1;
                end
            end
        end else begin
            run_len = 0;
        end
        if (!committed && m_clean == 1'b0) begin
            if (ks) armed = 1'b0;
            else if (!armed) begin armed = 1'b1; age = 0; end
            else begin
                age++;
                if (age == LONG && LONG_EN) l = 1'b1;
            end
        end
        expv = {m_clean, p, r, l};
        #1;
        if (key_press)   begin n_press++;   press_edge = edge_no;   end
        if (key_release) begin n_release++; release_edge = edge_no; end
        if (key_long)    begin n_long++;    long_edge = edge_no;    end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 4'b1000) begin
            failures++;
            $display("FAIL reset_values got=%b want=1000", obs);
        end
        rst_n = 1'b1;
        repeat (4) begin
            step(1'b1);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL reset_idle got=%b want=%b", obs, expv); end
        end
    endtask

    task automatic test_press_latency();
        int base;
        clear_obs();
        base = edge_no;
        repeat (10) begin
            step(1'b0);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL press_seq got=%b want=%b", obs, expv); end
        end
        checks++;
        if (press_edge - base !== DEB + 3) begin
            failures++;
            $display("FAIL press_latency got=%0d want=%0d", press_edge - base, DEB + 3);
        end
        repeat (10) begin
            step(1'b1);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL press_release_seq got=%b want=%b", obs, expv); end
        end
    endtask

    task automatic test_bounce();
        clear_obs();
        repeat (5) begin
            repeat (3) begin
                step(1'b0);
                checks++;
                if (obs !== expv) begin failures++; $display("FAIL bounce_low got=%b want=%b", obs, expv); end
            end
            repeat (2) begin
                step(1'b1);
                checks++;
                if (obs !== expv) begin failures++; $display("FAIL bounce_high got=%b want=%b", obs, expv); end
            end
        end
        repeat (8) begin
            step(1'b1);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL bounce_tail got=%b want=%b", obs, expv); end
        end
        checks++;
        if (n_press + n_release + n_long !== 0 || key_clean !== 1'b1) begin
            failures++;
            $display("FAIL bounce_pulses got=%0d/%b want=0/1", n_press + n_release + n_long, key_clean);
        end
    endtask

    task automatic test_press_release();
        int base;
        clear_obs();
        repeat (10) begin
            step(1'b0);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL pr_hold got=%b want=%b", obs, expv); end
        end
        base = edge_no;
        repeat (10) begin
            step(1'b1);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL pr_release got=%b want=%b", obs, expv); end
        end
        checks++;
        if (n_press !== 1 || n_release !== 1 || n_long !== 0) begin
            failures++;
            $display("FAIL pr_counts got=%0d/%0d/%0d want=1/1/0", n_press, n_release, n_long);
        end
        checks++;
        if (release_edge - base !== DEB + 3) begin
            failures++;
            $display("FAIL release_latency got=%0d want=%0d", release_edge - base, DEB + 3);
        end
    endtask

    task automatic test_long_press();
        clear_obs();
        repeat (40) begin
            step(1'b0);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL long_hold got=%b want=%b", obs, expv); end
        end
        checks++;
        if (n_long !== (LONG_EN ? 1 : 0)) begin
            failures++;
            $display("FAIL long_count got=%0d want=%0d", n_long, LONG_EN ? 1 : 0);
        end
        if (LONG_EN) begin
            checks++;
            if (long_edge - press_edge !== LONG) begin
                failures++;
                $display("FAIL long_latency got=%0d want=%0d", long_edge - press_edge, LONG);
            end
        end
        repeat (10) begin
            step(1'b1);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL long_release got=%b want=%b", obs, expv); end
        end
        checks++;
        if (n_release !== 1) begin
            failures++;
            $display("FAIL long_release_count got=%0d want=1", n_release);
        end
    endtask

    task automatic test_reset_pressed();
        int base;
        clear_obs();
        repeat (10) step(1'b0);
        checks++;
        if (key_clean !== 1'b0) begin failures++; $display("FAIL rp_pressed got=%b want=0", key_clean); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 4'b1000) begin failures++; $display("FAIL rp_async got=%b want=1000", obs); end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 4'b1000) begin failures++; $display("FAIL rp_held got=%b want=1000", obs); end
        rst_n = 1'b1;
        clear_obs();
        base = edge_no;
        repeat (10) begin
            step(1'b0);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL rp_after got=%b want=%b", obs, expv); end
        end
        checks++;
        if (n_release !== 0 || press_edge - base !== DEB + 3) begin
            failures++;
            $display("FAIL rp_repress got=rel%0d/lat%0d want=rel0/lat%0d", n_release, press_edge - base, DEB + 3);
        end
        repeat (10) step(1'b1);
    endtask

    task automatic test_release_bounce();
        clear_obs();
        repeat (10) step(1'b0);
        clear_obs();
        repeat (3) begin
            step(1'b1);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL rb_up got=%b want=%b", obs, expv); end
        end
        repeat (10) begin
            step(1'b0);
            checks++;
            if (obs !== expv) begin failures++; $display("FAIL rb_down got=%b want=%b", obs, expv); end
        end
        checks++;
        if (n_release !== 0 || key_clean !== 1'b0) begin
            failures++;
            $display("FAIL rb_result got=rel%0d/clean%b want=rel0/clean0", n_release, key_clean);
        end
        repeat (10) step(1'b1);
    endtask

    task automatic test_random();
        logic k;
        int len;
        k = 1'b1;
        for (int run = 0; run < 60; run++) begin
            k = ~k;
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 30) : $urandom_range(1, 8);
            repeat (len) begin
                step(k);
                checks++;
                if (obs !== expv) begin failures++; $display("FAIL random got=%b want=%b edge=%0d", obs, expv, edge_no); end
            end
        end
        repeat (10) step(1'b1);
    endtask

    initial begin
        edge_no = 0;
        clear_obs();
        test_reset();
        test_press_latency();
        test_bounce();
        test_press_release();
        test_long_press();
        test_reset_pressed();
        test_release_bounce();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
